l2_cmd_sequencer: RTL and testbench

L2_CMD_SEQUENCER -- requirements
Module: l2_cmd_sequencer

---
 rtl/l2_cmd_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_l2_cmd_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cmd_sequencer.sv
// Trace-driven L2 command sequencer: lookup, then optional writeback/fill/upgrade/snoop-writeback
// bus transactions, then a one-cycle update that writes tag/MESI/LRU and pulses done.
module l2_cmd_sequencer #(
  parameter int indexBits = 14,
  parameter int tagBits   = 12,
  parameter int ways      = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmdValid,
  input  logic [7:0]               command,
  input  logic [31:0]              address,
  output logic                     cmdReady,
  output logic                     lookupEn,
  input  logic                     lookupHit,
  input  logic [$clog2(ways)-1:0]  lookupWay,
  input  logic [1:0]               lookupMesi,
  input  logic [$clog2(ways)-1:0]  victimWay,
  input  logic                     victimDirty,
  output logic                     busReq,
  output logic [2:0]               busOp,
  input  logic                     busGrant,
  input  logic                     busDone,
  input  logic [1:0]               snoopResult,
  output logic                     lineWrite,
  output logic [$clog2(ways)-1:0]  writeWay,
  output logic [1:0]               mesiOut,
  output logic                     lruUpdate,
  output logic [$clog2(ways)-1:0]  lruWay,
  output logic                     clearAll,
  output logic                     done,
  output logic [31:0]              hitCount,
  output logic [31:0]              missCount
);

  localparam int WW = $clog2(ways);

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_RWIM  = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_WB    = 3'd4;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, UPGRADE, SNOOPWB, UPDATE, CLEAR} state_t;

  state_t          state, state_next;
  logic [7:0]      cmd;
  logic [31:0]     addr;
  logic            hit, shared, granted;
  logic [1:0]      mesi;
  logic [WW-1:0]   way, vway;
  logic            bus_phase, bus_fire, is_proc;
  logic            unused_addr;

  // Storage indexing is outside this block; the latched address is kept for trace visibility only.
  assign unused_addr = ^{addr[31 -: tagBits], addr[31-tagBits -: indexBits], addr};

  assign cmdReady  = (state == IDLE);
  assign is_proc   = (cmd <= 8'd2);
  assign bus_phase = (state == EVICT) || (state == FILL) || (state == UPGRADE) || (state == SNOOPWB);
  // A grant and done in the same cycle finish the transaction immediately.
  assign bus_fire  = bus_phase && busDone && (granted || busGrant);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= '0;
      addr      <= '0;
      hit       <= 1'b0;
      mesi      <= MESI_I;
      way       <= '0;
      vway      <= '0;
      shared    <= 1'b0;
      granted   <= 1'b0;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      state <= state_next;
      if (cmdValid && cmdReady) begin
        cmd  <= command;
        addr <= address;
      end
      if (state == LOOKUP) begin
        hit  <= lookupHit;
        way  <= lookupWay;
        mesi <= lookupMesi;
        vway <= victimWay;
        if (is_proc) begin
          if (lookupHit) begin
            if (hitCount != 32'hFFFF_FFFF) hitCount <= hitCount + 32'd1;
          end else if (missCount != 32'hFFFF_FFFF) begin
            missCount <= missCount + 32'd1;
          end
        end
      end
      if (bus_fire) granted <= 1'b0;
      else if (bus_phase && busGrant) granted <= 1'b1;
      if (state == FILL && bus_fire) shared <= (snoopResult != 2'd0);
    end
  end

  always_comb begin
    state_next = state;
    lookupEn   = 1'b0;
    busOp      = 3'd0;
    lineWrite  = 1'b0;
    writeWay   = '0;
    mesiOut    = MESI_I;
    lruUpdate  = 1'b0;
    lruWay     = '0;
    clearAll   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (cmdValid) begin
          if (command == 8'd8)      state_next = CLEAR;
          else if (command <= 8'd4) state_next = LOOKUP;
          else                      state_next = UPDATE;
        end
      end
      LOOKUP: begin
        lookupEn = 1'b1;
        case (cmd)
          8'd0, 8'd2: state_next = lookupHit ? UPDATE : (victimDirty ? EVICT : FILL);
          8'd1: begin
            if (lookupHit) state_next = (lookupMesi == MESI_S) ? UPGRADE : UPDATE;
            else           state_next = victimDirty ? EVICT : FILL;
          end
          8'd4:    state_next = (lookupHit && lookupMesi == MESI_M) ? SNOOPWB : UPDATE;
          default: state_next = UPDATE;
        endcase
      end
      EVICT: begin
        busOp = OP_WB;
        if (bus_fire) state_next = FILL;
      end
      FILL: begin
        busOp = (cmd == 8'd1) ? OP_RWIM : OP_READ;
        if (bus_fire) state_next = UPDATE;
      end
      UPGRADE: begin
        busOp = OP_INV;
        if (bus_fire) state_next = UPDATE;
      end
      SNOOPWB: begin
        busOp = OP_WB;
        if (bus_fire) state_next = UPDATE;
      end
      UPDATE: begin
        done       = 1'b1;
        state_next = IDLE;
        case (cmd)
          8'd0, 8'd2: begin
            lruUpdate = 1'b1;
            lruWay    = hit ? way : vway;
            if (!hit) begin
              lineWrite = 1'b1;
              writeWay  = vway;
              mesiOut   = shared ? MESI_S : MESI_E;
            end
          end
          8'd1: begin
            lineWrite = 1'b1;
            writeWay  = hit ? way : vway;
            mesiOut   = MESI_M;
            lruUpdate = 1'b1;
            lruWay    = hit ? way : vway;
          end
          8'd3: begin
            lineWrite = hit;
            writeWay  = way;
            mesiOut   = MESI_I;
          end
          8'd4: begin
            lineWrite = hit && (mesi == MESI_M || mesi == MESI_E);
            writeWay  = way;
            mesiOut   = MESI_S;
          end
          default: ;
        endcase
      end
      CLEAR: begin
        clearAll   = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busReq = bus_phase && !granted;
  end

endmodule

// File: tb/tb_l2_cmd_sequencer.sv
// Scoreboard bench: issued commands push expected update/bus results; a monitor checks them as they appear.
module tb_l2_cmd_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic [7:0]  command;
  logic [31:0] address;
  logic        cmdReady, lookupEn;
  logic        lookupHit;
  logic [2:0]  lookupWay;
  logic [1:0]  lookupMesi;
  logic [2:0]  victimWay;
  logic        victimDirty;
  logic        busReq;
  logic [2:0]  busOp;
  logic        busGrant, busDone;
  logic [1:0]  snoopResult;
  logic        lineWrite;
  logic [2:0]  writeWay;
  logic [1:0]  mesiOut;
  logic        lruUpdate;
  logic [2:0]  lruWay;
  logic        clearAll, done;
  logic [31:0] hitCount, missCount;

  always #5 clock = ~clock;

  l2_cmd_sequencer dut (
    .clock(clock), .reset(reset), .cmdValid(cmdValid), .command(command), .address(address),
    .cmdReady(cmdReady), .lookupEn(lookupEn), .lookupHit(lookupHit), .lookupWay(lookupWay),
    .lookupMesi(lookupMesi), .victimWay(victimWay), .victimDirty(victimDirty),
    .busReq(busReq), .busOp(busOp), .busGrant(busGrant), .busDone(busDone),
    .snoopResult(snoopResult), .lineWrite(lineWrite), .writeWay(writeWay), .mesiOut(mesiOut),
    .lruUpdate(lruUpdate), .lruWay(lruWay), .clearAll(clearAll), .done(done),
    .hitCount(hitCount), .missCount(missCount)
  );

  typedef struct {
    logic        lw;
    logic [2:0]  ww;
    logic [1:0]  mo;
    logic        lu;
    logic [2:0]  lwy;
    logic        clr;
    int          lat;
    int          lookups;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t        exp_q[$];
  logic [2:0]  bus_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hits = 0;
  logic [31:0] m_miss = 0;
  logic [1:0]  cur_snoop = 2'd0;
  bit          hold_grant = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: outcome of one command from the cache-protocol rules.
  task automatic issue(input logic [7:0] c, input logic [31:0] a, input logic h, input logic [2:0] w,
                       input logic [1:0] m, input logic [2:0] vw, input logic vd,
                       input logic [1:0] sr, input int gap);
    exp_t e;
    int   n;
    e.lw = 0; e.ww = 0; e.mo = 0; e.lu = 0; e.lwy = 0; e.clr = 0; e.lat = 0; e.lookups = 0;
    if (c == 8) begin
      e.clr = 1; e.lat = 1;
    end else if (c > 4) begin
      e.lat = 1;
    end else begin
      e.lookups = 1;
      if (c <= 2) begin
        if (h) m_hits++; else m_miss++;
      end
      if (c == 0 || c == 2) begin
        e.lu = 1;
        if (h) begin
          e.lwy = w; e.lat = 2;
        end else begin
          if (vd) bus_q.push_back(3'd4);
          bus_q.push_back(3'd1);
          e.lw = 1; e.ww = vw; e.mo = (sr != 0) ? 2'd1 : 2'd2; e.lwy = vw;
        end
      end else if (c == 1) begin
        e.lw = 1; e.mo = 2'd3; e.lu = 1;
        if (h) begin
          if (m == 2'd1) bus_q.push_back(3'd3); else e.lat = 2;
          e.ww = w; e.lwy = w;
        end else begin
          if (vd) bus_q.push_back(3'd4);
          bus_q.push_back(3'd2);
          e.ww = vw; e.lwy = vw;
        end
      end else if (c == 3) begin
        e.lat = 2;
        if (h) begin e.lw = 1; e.ww = w; e.mo = 2'd0; end
      end else begin
        if (h && m == 2'd3) begin
          bus_q.push_back(3'd4);
          e.lw = 1; e.ww = w; e.mo = 2'd1;
        end else begin
          e.lat = 2;
          if (h && m == 2'd2) begin e.lw = 1; e.ww = w; e.mo = 2'd1; end
        end
      end
    end
    e.hc = m_hits;
    e.mc = m_miss;
    exp_q.push_back(e);
    repeat (gap) begin @(posedge clock); #1; end
    n = 0;
    while (!cmdReady && n < 500) begin @(posedge clock); #1; n++; end
    if (!cmdReady) begin
      check("cmd_ready_timeout", {31'd0, cmdReady}, 32'd1);
    end else begin
      cmdValid = 1; command = c; address = a; lookupHit = h; lookupWay = w; lookupMesi = m;
      victimWay = vw; victimDirty = vd; cur_snoop = sr;
      @(posedge clock); #1;
      cmdValid = 0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(posedge clock); #1; n++; end
    check(name, exp_q.size(), 0);
  endtask

  // Bus agent: random grant/done delays, plus stray grant/done pulses the DUT must ignore.
  initial begin
    busGrant = 0; busDone = 0; snoopResult = 0;
    forever begin
      @(posedge clock); #1;
      busGrant = 0; busDone = 0; snoopResult = cur_snoop;
      if (!reset) begin
        if (busOp == 3'd0) begin
          if ($urandom_range(0, 7) == 0) begin busGrant = 1; busDone = 1; end
        end else if (busReq) begin
          if (!hold_grant && $urandom_range(0, 2) == 0) begin
            busGrant = 1;
            busDone  = ($urandom_range(0, 3) == 0);
          end
        end else begin
          busGrant = ($urandom_range(0, 3) == 0);
          busDone  = ($urandom_range(0, 2) == 0);
        end
      end
    end
  end

  // Monitor
  initial begin
    int         cyc = 0;
    int         acc_cyc = 0;
    int         lk = 0;
    logic       prev_wait = 0;
    logic [2:0] prev_op = 0;
    exp_t       e;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        prev_wait = 0;
        continue;
      end
      if (cmdValid && cmdReady) begin acc_cyc = cyc; lk = 0; end
      if (lookupEn) lk++;
      if (prev_wait) check("bus_req_hold", {28'd0, busReq, busOp}, {28'd0, 1'b1, prev_op});
      if (busReq && busGrant) begin
        if (bus_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_unexpected: busOp=%0d granted, expected no transaction", busOp);
        end else begin
          check("bus_op", busOp, bus_q.pop_front());
        end
      end
      prev_wait = busReq && !busGrant;
      prev_op   = busOp;
      if (!done) begin
        check("stray_update", {29'd0, lineWrite, lruUpdate, clearAll}, 32'd0);
      end else begin
        check("done_with_ready", cmdReady, 0);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: done=1, expected no completion");
        end else begin
          e = exp_q.pop_front();
          check("lineWrite", lineWrite, e.lw);
          if (e.lw) begin
            check("writeWay", writeWay, e.ww);
            check("mesiOut", mesiOut, e.mo);
          end
          check("lruUpdate", lruUpdate, e.lu);
          if (e.lu) check("lruWay", lruWay, e.lwy);
          check("clearAll", clearAll, e.clr);
          if (e.lat != 0) check("latency", cyc - acc_cyc, e.lat);
          check("lookup_cycles", lk, e.lookups);
          check("hitCount", hitCount, e.hc);
          check("missCount", missCount, e.mc);
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_cmdReady"}, cmdReady, 1);
    check({tag, "_busReq"}, busReq, 0);
    check({tag, "_busOp"}, busOp, 0);
    check({tag, "_outs"}, {26'd0, lookupEn, lineWrite, lruUpdate, clearAll, done, |mesiOut}, 0);
    check({tag, "_hitCount"}, hitCount, 0);
    check({tag, "_missCount"}, missCount, 0);
  endtask

  initial begin
    int n;
    logic [7:0] c;
    int r;
    reset = 1; cmdValid = 0; command = 0; address = 0; lookupHit = 0; lookupWay = 0;
    lookupMesi = 0; victimWay = 0; victimDirty = 0;
    #3;
    check_reset_state("reset0");
    @(negedge clock); #2 reset = 0;
    @(posedge clock); #1;

    // Directed scenarios
    issue(8'd0, 32'h0000_1234, 1, 3'd5, 2'd2, 3'd0, 0, 2'd0, 0);
    issue(8'd1, 32'h0040_0080, 0, 3'd0, 2'd0, 3'd2, 1, 2'd0, 1);
    issue(8'd0, 32'h0012_3400, 0, 3'd1, 2'd0, 3'd3, 0, 2'd0, 0);
    issue(8'd1, 32'h00AB_C000, 1, 3'd4, 2'd1, 3'd0, 0, 2'd0, 2);
    issue(8'd4, 32'h0777_0040, 1, 3'd6, 2'd3, 3'd1, 0, 2'd0, 0);
    issue(8'd2, 32'h1000_0000, 0, 3'd0, 2'd0, 3'd7, 0, 2'd2, 0);
    issue(8'd3, 32'h2000_0000, 1, 3'd3, 2'd3, 3'd0, 0, 2'd0, 0);
    issue(8'd4, 32'h3000_0000, 1, 3'd2, 2'd2, 3'd0, 0, 2'd0, 0);
    issue(8'd4, 32'h3000_0040, 1, 3'd2, 2'd1, 3'd0, 0, 2'd0, 0);
    issue(8'd8, 32'h0, 0, 3'd0, 2'd0, 3'd0, 0, 2'd0, 0);
    issue(8'd7, 32'h0, 1, 3'd1, 2'd3, 3'd1, 1, 2'd0, 0);
    issue(8'd255, 32'h0, 0, 3'd0, 2'd0, 3'd0, 0, 2'd0, 1);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 7);
      if (r <= 4)      c = 8'(r);
      else if (r == 5) c = 8'd8;
      else if (r == 6) c = 8'($urandom_range(5, 7));
      else             c = 8'($urandom_range(9, 255));
      issue(c, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 2)), $urandom_range(0, 3));
    end
    drain("drain_random");

    // Reset while a writeback waits for grant
    hold_grant = 1;
    issue(8'd1, 32'h0000_5000, 0, 3'd0, 2'd0, 3'd2, 1, 2'd0, 0);
    n = 0;
    while (!busReq && n < 50) begin @(negedge clock); n++; end
    check("reset_test_busreq_seen", busReq, 1);
    @(negedge clock);
    #2 reset = 1;
    #1;
    check_reset_state("reset_mid_bus");
    exp_q.delete();
    bus_q.delete();
    m_hits = 0;
    m_miss = 0;
    hold_grant = 0;
    repeat (2) @(negedge clock);
    #2 reset = 0;
    @(posedge clock); #1;
    issue(8'd7, 32'h0, 0, 3'd0, 2'd0, 3'd0, 0, 2'd0, 0);
    issue(8'd2, 32'h0000_0100, 1, 3'd3, 2'd2, 3'd0, 0, 2'd0, 0);
    drain("drain_after_reset");
    check("bus_queue_empty", bus_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
